// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with one-entry skid buffer, branch drop and HLT stop.
// Define FETCH_PERF_EN to add the fetch_bubbles idle-cycle counter output.
module fetch_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc2,
  output logic        if_id_valid,
  output logic [3:0]  opcode,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] fetch_bubbles
`endif
);
  typedef enum logic [1:0] {RUN, SKID, DROP, HALT} state_t;
  state_t      r_state, w_state;
  logic        r_live, r_valid, w_valid, w_vld;
  logic [15:0] r_faddr, w_faddr, r_tgt, w_tgt, r_sk_instr, w_sk_instr;
  logic [15:0] r_sk_pc2, w_sk_pc2, r_instr, w_instr, r_pc2, w_pc2, w_next_pc;
  // r_live keeps the request low until the first clock after reset release
  assign imem_req    = r_live && (r_state == RUN || r_state == DROP);
  assign w_vld       = imem_valid && imem_req;
  assign w_next_pc   = r_faddr + 16'd2;
  assign imem_addr   = r_faddr;
  assign if_id_instr = r_instr;
  assign if_id_pc2   = r_pc2;
  assign if_id_valid = r_valid;
  assign opcode      = r_instr[15:12];
  assign halted      = r_state == HALT;
  always_comb begin
    w_state    = r_state;
    w_faddr    = r_faddr;
    w_tgt      = r_tgt;
    w_sk_instr = r_sk_instr;
    w_sk_pc2   = r_sk_pc2;
    w_instr    = r_instr;
    w_pc2      = r_pc2;
    w_valid    = r_valid;
    case (r_state)
      RUN: begin
        if (branch_taken) begin
          w_instr = '0;
          w_valid = 1'b0;
          w_tgt   = branch_target;
          w_faddr = w_vld ? branch_target : r_faddr;
          w_state = w_vld ? RUN : DROP;
        end else if (w_vld) begin
          w_faddr = w_next_pc;
          if (stall) begin
            w_sk_instr = imem_rdata;
            w_sk_pc2   = w_next_pc;
            w_state    = SKID;
          end else begin
            w_instr = imem_rdata;
            w_pc2   = w_next_pc;
            w_valid = 1'b1;
            w_state = imem_rdata[15:12] == 4'hF ? HALT : RUN;
          end
        end
      end
      SKID: begin
        if (branch_taken) begin
          w_instr = '0;
          w_valid = 1'b0;
          w_faddr = branch_target;
          w_state = RUN;
        end else if (!stall) begin
          w_instr = r_sk_instr;
          w_pc2   = r_sk_pc2;
          w_valid = 1'b1;
          w_state = r_sk_instr[15:12] == 4'hF ? HALT : RUN;
        end
      end
      // the outstanding word is thrown away; the newest target wins
      DROP: begin
        w_tgt = branch_taken ? branch_target : r_tgt;
        if (w_vld) begin
          w_faddr = w_tgt;
          w_state = RUN;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_live     <= 1'b0;
      r_faddr    <= '0;
      r_tgt      <= '0;
      r_sk_instr <= '0;
      r_sk_pc2   <= '0;
      r_instr    <= '0;
      r_pc2      <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_live     <= 1'b1;
      r_faddr    <= w_faddr;
      r_tgt      <= w_tgt;
      r_sk_instr <= w_sk_instr;
      r_sk_pc2   <= w_sk_pc2;
      r_instr    <= w_instr;
      r_pc2      <= w_pc2;
      r_valid    <= w_valid;
    end
  end
`ifdef FETCH_PERF_EN
  logic [15:0] r_bubbles;
  assign fetch_bubbles = r_bubbles;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_bubbles <= '0;
    else if (!r_valid && r_state != HALT && r_bubbles != 16'hFFFF) r_bubbles <= r_bubbles + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random and directed stimulus against a transaction-level fetch model with a load scoreboard.
module tb_fetch_stage;
  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, branch_taken = 1'b0, imem_valid = 1'b0;
  logic [15:0] branch_target = '0, imem_rdata = '0;
  logic        imem_req, if_id_valid, halted;
  logic [15:0] imem_addr, if_id_instr, if_id_pc2;
  logic [3:0]  opcode;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_bubbles;
`endif
  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .if_id_instr(if_id_instr),
    .if_id_pc2(if_id_pc2), .if_id_valid(if_id_valid), .opcode(opcode), .halted(halted)
`ifdef FETCH_PERF_EN
    , .fetch_bubbles(fetch_bubbles)
`endif
  );
  always #5 clk = ~clk;

  typedef struct packed {logic [15:0] instr; logic [15:0] pc2;} ent_t;
  ent_t q[$];
  int total = 0, bad = 0;
  // reference model: fetch pointer, pending discard, parked word, halt, IF/ID validity
  logic        m_live, m_halt, m_park, m_drop, m_ifv;
  logic [15:0] m_addr, m_tgt, m_pk_i, m_pk_p, m_bub;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic deliver(input logic [15:0] w, input logic [15:0] p);
    ent_t t;
    t.instr = w;
    t.pc2 = p;
    q.push_back(t);
    m_ifv = 1'b1;
    if (w[15:12] == 4'hF) m_halt = 1'b1;
  endtask

  task automatic step(input logic st, input logic br, input logic [15:0] bt, input logic v, input logic [15:0] rd);
    logic req, vv;
    @(negedge clk);
    req = m_live && !m_halt && !m_park;
    chk("imem_req", 32'(imem_req), 32'(req));
    if (req) chk("imem_addr", 32'(imem_addr), 32'(m_addr));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("if_id_valid", 32'(if_id_valid), 32'(m_ifv));
    if (!m_ifv) chk("flushed_instr", 32'(if_id_instr), 0);
`ifdef FETCH_PERF_EN
    chk("fetch_bubbles", 32'(fetch_bubbles), 32'(m_bub));
`endif
    vv = v && req;
    stall = st;
    branch_taken = br;
    branch_target = bt;
    imem_valid = vv;
    imem_rdata = rd;
    if (!m_ifv && !m_halt && m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
    if (m_halt) begin
    end else if (m_park) begin
      if (br) begin
        m_park = 1'b0;
        m_addr = bt;
        m_ifv = 1'b0;
      end else if (!st) begin
        m_park = 1'b0;
        deliver(m_pk_i, m_pk_p);
      end
    end else if (m_drop) begin
      if (br) m_tgt = bt;
      if (vv) begin
        m_addr = m_tgt;
        m_drop = 1'b0;
      end
    end else if (br) begin
      m_ifv = 1'b0;
      if (vv) m_addr = bt;
      else begin
        m_drop = 1'b1;
        m_tgt = bt;
      end
    end else if (vv) begin
      if (st) begin
        m_park = 1'b1;
        m_pk_i = rd;
        m_pk_p = m_addr + 16'd2;
      end else deliver(rd, m_addr + 16'd2);
      m_addr = m_addr + 16'd2;
    end
    m_live = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    imem_valid = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_instr", 32'(if_id_instr), 0);
    chk("rst_pc2", 32'(if_id_pc2), 0);
    chk("rst_valid", 32'(if_id_valid), 0);
    chk("rst_opcode", 32'(opcode), 0);
    chk("rst_halted", 32'(halted), 0);
    q.delete();
    {m_live, m_halt, m_park, m_drop, m_ifv} = '0;
    {m_addr, m_tgt, m_pk_i, m_pk_p, m_bub} = '0;
    @(negedge clk);
    imem_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    imem_valid = 1'b0;
    #1;
    chk("release_req", 32'(imem_req), 0);
`ifdef FETCH_PERF_EN
    chk("release_bubbles", 32'(fetch_bubbles), 0);
`endif
    m_live = 1'b1;
    m_bub = 16'd1;
  endtask

  task automatic rand_step(input bit allow_hlt);
    logic [15:0] rd;
    rd = 16'($urandom);
    if (rd[15:12] == 4'hF && !(allow_hlt && $urandom_range(0, 15) == 0)) rd[15:12] = 4'hE;
    step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, 16'($urandom) & 16'hFFFE,
         $urandom_range(0, 2) == 0, rd);
  endtask

  logic        pv = 1'b0;
  logic [15:0] pi = '0, pp = '0;
  ent_t        me;
  always @(negedge clk) begin
    if (rst_n && if_id_valid && (!pv || if_id_instr !== pi || if_id_pc2 !== pp)) begin
      if (q.size() == 0) chk("unexpected_load", {if_id_instr, if_id_pc2}, 32'hFFFF_FFFF);
      else begin
        me = q.pop_front();
        chk("ifid_instr", 32'(if_id_instr), 32'(me.instr));
        chk("ifid_pc2", 32'(if_id_pc2), 32'(me.pc2));
        chk("opcode", 32'(opcode), 32'(me.instr[15:12]));
      end
    end
    pv = if_id_valid;
    pi = if_id_instr;
    pp = if_id_pc2;
  end

  initial begin
`ifdef FETCH_PERF_EN
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 16'h3000);
    @(negedge clk);
    chk("perf_first_valid", 32'(if_id_valid), 1);
    chk("perf_bubbles_5", 32'(fetch_bubbles), 5);
`endif
    do_reset();
    step(0, 0, 0, 1, 16'h1234);
    step(0, 0, 0, 1, 16'h5678);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 16'hA5A5);
    step(1, 0, 0, 0, 0);
    chk("skid_hold_instr", 32'(if_id_instr), 32'h5678);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("skid_release_instr", 32'(if_id_instr), 32'hA5A5);
    step(0, 1, 16'h0040, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 16'hBEEF);
    step(0, 0, 0, 0, 0);
    chk("drop_addr", 32'(imem_addr), 32'h0040);
    step(0, 1, 16'h0080, 1, 16'hF000);
    step(0, 0, 0, 0, 0);
    chk("hlt_discarded", 32'(halted), 0);
    step(0, 0, 0, 1, 16'hF000);
    for (int i = 0; i < 4; i++) rand_step(1'b1);
    chk("halt_sticky", 32'(halted), 1);
    chk("halt_instr", 32'(if_id_instr), 32'hF000);
    do_reset();
    step(0, 1, 16'hFFFC, 1, 16'h9999);
    step(0, 0, 0, 1, 16'h0101);
    step(0, 0, 0, 1, 16'h0202);
    step(0, 0, 0, 0, 0);
    chk("wrap_addr", 32'(imem_addr), 0);
    step(0, 0, 0, 1, 16'h1111);
    step(0, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 1, 16'h2222);
    for (int i = 0; i < 400; i++) rand_step(1'b0);
    do_reset();
    for (int i = 0; i < 400; i++) rand_step(1'b1);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
